// File: rtl/spdif_frame_tx_if.sv
// Sample-pair handshake between an audio source and the S/PDIF transmitter.
// A pair transfers on a clock where s_valid and s_ready are both high.
interface spdif_frame_tx_if #(
  parameter int SAMPLE_W = 24
);
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_left;
  logic [SAMPLE_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/spdif_frame_tx.sv
// IEC 60958 biphase-mark transmitter: one-deep stereo holding buffer, B/M/W preambles,
// V/U/C/P slots and a continuously running line once reset is released.
module spdif_frame_tx #(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = 24,
  parameter int BLK_LEN  = 192
) (
  input  logic            clk,
  input  logic            rst,
  spdif_frame_tx_if.slave s_bus,
  input  logic [31:0]     cs_bits,
  output logic            spdif_out,
  output logic            block_start,
  output logic            underrun
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRM_W = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;

  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  typedef enum logic {PRE = 1'b0, DATA = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic                run_reg;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic [6:0]          ui_cnt_reg;
  logic [FRM_W-1:0]    frame_cnt_reg;
  logic                line_reg, line_next;
  logic                pol_reg;
  logic                full_reg;
  logic [SAMPLE_W-1:0] buf_left_reg, buf_right_reg;
  logic [SAMPLE_W-1:0] left_sh_reg, right_sh_reg;
  logic                v_reg;
  logic [31:0]         cs_reg;
  logic                block_start_reg, underrun_reg;

  logic                ui_tick, frame_begin, subframe_begin, accept;
  logic [6:0]          ui_idx;
  logic [FRM_W-1:0]    frame_idx, cur_frame;
  logic [SAMPLE_W-1:0] sample_sel;
  logic [23:0]         audio_field;
  logic [31:0]         sub_word;
  logic [7:0]          pre_pat;
  logic                c_bit, pol_now;

  assign s_bus.s_ready = ~full_reg;
  assign accept        = s_bus.s_valid & ~full_reg;
  assign spdif_out     = line_reg;
  assign block_start   = block_start_reg;
  assign underrun      = underrun_reg;

  // The very first edge after reset starts UI 0 of frame 0 without waiting for the divider.
  always_comb begin
    ui_tick   = ~run_reg | (div_cnt_reg == DIV_W'(CLK_DIV - 1));
    ui_idx    = run_reg ? (ui_cnt_reg + 7'd1) : 7'd0;
    frame_idx = frame_cnt_reg;
    if (!run_reg) begin
      frame_idx = '0;
    end else if (ui_cnt_reg == 7'd127) begin
      frame_idx = (frame_cnt_reg == FRM_W'(BLK_LEN - 1)) ? '0 : frame_cnt_reg + 1'b1;
    end
    frame_begin    = ui_tick & (ui_idx == 7'd0);
    subframe_begin = ui_tick & (ui_idx[5:0] == 6'd0);
    cur_frame      = frame_begin ? frame_idx : frame_cnt_reg;
  end

  // Subframe slot word; the sample is MSB-aligned so its top bit always lands in slot 27.
  always_comb begin
    sample_sel  = ui_idx[6] ? right_sh_reg : left_sh_reg;
    audio_field = 24'(sample_sel) << (24 - SAMPLE_W);
    c_bit       = (32'(frame_cnt_reg) < 32'd32) ? cs_reg[5'(frame_cnt_reg)] : 1'b0;
    sub_word        = '0;
    sub_word[27:4]  = audio_field;
    sub_word[28]    = v_reg;
    sub_word[29]    = 1'b0;
    sub_word[30]    = c_bit;
    sub_word[31]    = ^sub_word[30:4];
    if (ui_idx[6])
      pre_pat = PRE_W;
    else if (cur_frame == '0)
      pre_pat = PRE_B;
    else
      pre_pat = PRE_M;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= PRE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (ui_tick)
      state_next = (ui_idx[5:3] == 3'd0) ? PRE : DATA;
  end

  // Preamble polarity follows the line level left by the previous subframe.
  always_comb begin
    line_next = line_reg;
    pol_now   = subframe_begin ? line_reg : pol_reg;
    if (ui_tick) begin
      if (state_next == PRE)
        line_next = pre_pat[3'd7 - ui_idx[2:0]] ^ pol_now;
      else if (!ui_idx[0])
        line_next = ~line_reg;
      else
        line_next = line_reg ^ sub_word[ui_idx[5:1]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg         <= 1'b0;
      div_cnt_reg     <= '0;
      ui_cnt_reg      <= '0;
      frame_cnt_reg   <= '0;
      line_reg        <= 1'b0;
      pol_reg         <= 1'b0;
      full_reg        <= 1'b0;
      buf_left_reg    <= '0;
      buf_right_reg   <= '0;
      left_sh_reg     <= '0;
      right_sh_reg    <= '0;
      v_reg           <= 1'b0;
      cs_reg          <= '0;
      block_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      run_reg         <= 1'b1;
      line_reg        <= line_next;
      div_cnt_reg     <= ui_tick ? '0 : div_cnt_reg + 1'b1;
      block_start_reg <= frame_begin & (frame_idx == '0);
      underrun_reg    <= frame_begin & ~full_reg;
      if (ui_tick)
        ui_cnt_reg <= ui_idx;
      if (subframe_begin)
        pol_reg <= line_reg;
      if (frame_begin) begin
        frame_cnt_reg <= frame_idx;
        left_sh_reg   <= full_reg ? buf_left_reg  : '0;
        right_sh_reg  <= full_reg ? buf_right_reg : '0;
        v_reg         <= ~full_reg;
        if (frame_idx == '0)
          cs_reg <= cs_bits;
      end
      // A pair accepted on the load clock stays buffered for the following frame.
      if (accept) begin
        full_reg      <= 1'b1;
        buf_left_reg  <= s_bus.s_left;
        buf_right_reg <= s_bus.s_right;
      end else if (frame_begin) begin
        full_reg <= 1'b0;
      end
    end
  end
endmodule
